// File: rtl/mc_cr_pkg.sv
// mc_cr_pkg: types and constants shared by the mc_cr chroma MC blocks.
//   state_t        : interpolator control states
//   FRAC_W         : width of the 1/8-pel fraction
//   ROUND_C/SHIFT_C: rounding offset and normalising shift of the bilinear sum
//   bilin_weights(): the four H.264 chroma bilinear weights for a (dx,dy)
package mc_cr_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FIRST = 2'd1,
    RUN   = 2'd2
  } state_t;

  localparam int FRAC_W  = 3;
  localparam int WGT_W   = 7;   // weights reach 64, so 7 bits
  localparam int ROUND_C = 32;
  localparam int SHIFT_C = 6;

  typedef struct packed {
    logic [WGT_W-1:0] wa;  // top-left     (8-dx)(8-dy)
    logic [WGT_W-1:0] wb;  // top-right    dx(8-dy)
    logic [WGT_W-1:0] wc;  // bottom-left  (8-dx)dy
    logic [WGT_W-1:0] wd;  // bottom-right dx*dy
  } bilin_wgt_t;

  function automatic bilin_wgt_t bilin_weights(input logic [FRAC_W-1:0] dx,
                                               input logic [FRAC_W-1:0] dy);
    bilin_wgt_t       w;
    logic [WGT_W-1:0] lx;
    logic [WGT_W-1:0] ly;
    logic [WGT_W-1:0] hx;
    logic [WGT_W-1:0] hy;
    lx   = {4'd0, dx};
    ly   = {4'd0, dy};
    hx   = 7'd8 - lx;
    hy   = 7'd8 - ly;
    // every product is at most 64, so the 7-bit context never truncates
    w.wa = hx * hy;
    w.wb = lx * hy;
    w.wc = hx * ly;
    w.wd = lx * ly;
    return w;
  endfunction

endpackage

// File: rtl/mc_cr_bilin_pe.sv
// mc_cr_bilin_pe: one-pixel combinational bilinear chroma kernel.
//   a,b   : upper-row pixels j and j+1
//   c,d   : lower-row pixels j and j+1
//   dx,dy : 1/8-pel fraction
//   pred  : ((wa*a + wb*b + wc*c + wd*d) + 32) >> 6
module mc_cr_bilin_pe
  import mc_cr_pkg::*;
#(
  parameter int PIX_W = 8
) (
  input  logic [PIX_W-1:0]  a,
  input  logic [PIX_W-1:0]  b,
  input  logic [PIX_W-1:0]  c,
  input  logic [PIX_W-1:0]  d,
  input  logic [FRAC_W-1:0] dx,
  input  logic [FRAC_W-1:0] dy,
  output logic [PIX_W-1:0]  pred
);

  localparam int ACC_W = PIX_W + WGT_W;

  bilin_wgt_t       wgt_s;
  logic [ACC_W-1:0] acc_s;
  logic             unused_s;

  assign wgt_s = bilin_weights(dx, dy);

  // Weights sum to 64, so the rounded sum stays below 64*2^PIX_W.
  assign acc_s = ACC_W'(wgt_s.wa) * ACC_W'(a)
               + ACC_W'(wgt_s.wb) * ACC_W'(b)
               + ACC_W'(wgt_s.wc) * ACC_W'(c)
               + ACC_W'(wgt_s.wd) * ACC_W'(d)
               + ACC_W'(ROUND_C);

  // After the shift the result always fits PIX_W bits; no clip needed.
  assign pred = acc_s[SHIFT_C +: PIX_W];

  // Rounding bits and the always-zero top bit are intentionally dropped.
  assign unused_s = ^{acc_s[SHIFT_C-1:0], acc_s[ACC_W-1:PIX_W+SHIFT_C]};

endmodule

// File: rtl/mc_cr_interp.sv
// mc_cr_interp: H.264 chroma bilinear interpolation datapath.
//   cmd_*  : (dx,dy) command, accepted only when idle
//   src_*  : BLK_H+1 reference rows of BLK_W+1 pixels per command
//   dst_*  : BLK_H predicted rows of BLK_W pixels, dst_last on the final row
//   clk, reset (asynchronous, active-high)
module mc_cr_interp
  import mc_cr_pkg::*;
#(
  parameter int BLK_W = 4,
  parameter int BLK_H = 4,
  parameter int PIX_W = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       cmd_valid,
  output logic                       cmd_ready,
  input  logic [FRAC_W-1:0]          cmd_dx,
  input  logic [FRAC_W-1:0]          cmd_dy,
  input  logic                       src_valid,
  output logic                       src_ready,
  input  logic [(BLK_W+1)*PIX_W-1:0] src_row,
  output logic                       dst_valid,
  input  logic                       dst_ready,
  output logic [BLK_W*PIX_W-1:0]     dst_row,
  output logic                       dst_last
);

  localparam int ROW_W = (BLK_W + 1) * PIX_W;
  localparam int OUT_W = BLK_W * PIX_W;
  localparam int CNT_W = $clog2(BLK_H + 1);

  state_t             state_r;
  logic [FRAC_W-1:0]  dx_r;
  logic [FRAC_W-1:0]  dy_r;
  logic [ROW_W-1:0]   prev_row_r;
  logic [CNT_W-1:0]   cnt_r;
  logic [OUT_W-1:0]   bilin_row_s;
  logic               src_fire_s;
  logic               dst_fire_s;

  // One kernel per output pixel: prev_row is the upper row, src_row the lower.
  for (genvar j = 0; j < BLK_W; j++) begin : g_pe
    mc_cr_bilin_pe #(.PIX_W(PIX_W)) u_pe (
      .a    (prev_row_r[j*PIX_W +: PIX_W]),
      .b    (prev_row_r[(j+1)*PIX_W +: PIX_W]),
      .c    (src_row[j*PIX_W +: PIX_W]),
      .d    (src_row[(j+1)*PIX_W +: PIX_W]),
      .dx   (dx_r),
      .dy   (dy_r),
      .pred (bilin_row_s[j*PIX_W +: PIX_W])
    );
  end

  // Source acceptance: the output slot must be free or draining this cycle,
  // and no more than BLK_H rows are taken after the first one.
  always_comb begin
    src_ready = 1'b0;
    case (state_r)
      FIRST:   src_ready = 1'b1;
      RUN:     src_ready = (cnt_r < CNT_W'(BLK_H)) && (!dst_valid || dst_ready);
      default: src_ready = 1'b0;
    endcase
  end

  assign src_fire_s = src_valid && src_ready;
  assign dst_fire_s = dst_valid && dst_ready;

  // Control FSM with registered command/destination outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r    <= IDLE;
      cmd_ready  <= 1'b1;
      dx_r       <= '0;
      dy_r       <= '0;
      prev_row_r <= '0;
      cnt_r      <= '0;
      dst_valid  <= 1'b0;
      dst_row    <= '0;
      dst_last   <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (cmd_valid) begin
            dx_r      <= cmd_dx;
            dy_r      <= cmd_dy;
            cnt_r     <= '0;
            cmd_ready <= 1'b0;
            state_r   <= FIRST;
          end
        end
        FIRST: begin
          if (src_valid) begin
            prev_row_r <= src_row;
            state_r    <= RUN;
          end
        end
        RUN: begin
          // The final row is only handshaken once all sources are in, so
          // exit never coincides with a source acceptance.
          if (dst_fire_s && dst_last) begin
            dst_valid <= 1'b0;
            dst_last  <= 1'b0;
            cmd_ready <= 1'b1;
            state_r   <= IDLE;
          end else if (src_fire_s) begin
            dst_row    <= bilin_row_s;
            dst_valid  <= 1'b1;
            dst_last   <= (cnt_r == CNT_W'(BLK_H - 1));
            prev_row_r <= src_row;
            cnt_r      <= cnt_r + 1'b1;
          end else if (dst_fire_s) begin
            dst_valid <= 1'b0;
          end
        end
        default: begin
          state_r   <= IDLE;
          cmd_ready <= 1'b1;
          dst_valid <= 1'b0;
          dst_last  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mc_cr_interp.sv
// tb_mc_cr_interp: randomized self-checking bench for mc_cr_interp.
// Expected rows come from the bilinear formula evaluated on the reference
// pixel array with integer arithmetic.
module tb_mc_cr_interp;

  localparam int BW = 4;
  localparam int BH = 4;
  localparam int PW = 8;

  logic                   clk = 1'b0;
  logic                   reset;
  logic                   cmd_valid;
  logic                   cmd_ready;
  logic [2:0]             cmd_dx;
  logic [2:0]             cmd_dy;
  logic                   src_valid;
  logic                   src_ready;
  logic [(BW+1)*PW-1:0]   src_row;
  logic                   dst_valid;
  logic                   dst_ready;
  logic [BW*PW-1:0]       dst_row;
  logic                   dst_last;

  int n_chk = 0;
  int n_err = 0;
  int cyc = 0;
  int last_dst_cyc = -100;
  bit expect_b2b = 1'b0;
  logic [7:0] refpix [BH+1][BW+1];

  mc_cr_interp #(.BLK_W(BW), .BLK_H(BH), .PIX_W(PW)) dut (
    .clk       (clk),
    .reset     (reset),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_dx    (cmd_dx),
    .cmd_dy    (cmd_dy),
    .src_valid (src_valid),
    .src_ready (src_ready),
    .src_row   (src_row),
    .dst_valid (dst_valid),
    .dst_ready (dst_ready),
    .dst_row   (dst_row),
    .dst_last  (dst_last)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int pred(int a, int b, int c, int d, int dx, int dy);
    return ((8-dx)*(8-dy)*a + dx*(8-dy)*b + (8-dx)*dy*c + dx*dy*d + 32) / 64;
  endfunction

  // pat: 1 = 10*r+i ramp, 2 = {0,255,...}, 3 = single 255 at ref[1][1], else random
  task automatic fill_rows(input int pat);
    for (int r = 0; r <= BH; r++)
      for (int i = 0; i <= BW; i++)
        case (pat)
          1:       refpix[r][i] = 8'(10*r + i);
          2:       refpix[r][i] = (i % 2 == 1) ? 8'd255 : 8'd0;
          3:       refpix[r][i] = (r == 1 && i == 1) ? 8'd255 : 8'd0;
          default: refpix[r][i] = 8'($urandom_range(0, 255));
        endcase
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_cmd_ready"}, cmd_ready, 1);
    chk({tag, "_src_ready"}, src_ready, 0);
    chk({tag, "_dst_valid"}, dst_valid, 0);
    chk({tag, "_dst_row"},   dst_row,   0);
    chk({tag, "_dst_last"},  dst_last,  0);
  endtask

  // rdy_mode: 0 = always ready (src always valid), 1 = random, 2 = stall 3 cycles
  task automatic run_block(input int dx, input int dy, input int pat, input int rdy_mode,
                           input int abort_at, input bit hold_after,
                           input int next_dx, input int next_dy);
    logic [BW*PW-1:0] exp_rows [BH];
    logic [BW*PW-1:0] held_row;
    logic             held_last;
    bit               held_valid = 1'b0;
    bit               cmd_sent = 1'b0;
    bit               seen_valid = 1'b0;
    int               rows = 0;
    int               outs = 0;
    int               stall = 0;
    fill_rows(pat);
    for (int r = 0; r < BH; r++)
      for (int j = 0; j < BW; j++)
        exp_rows[r][j*PW +: PW] = 8'(pred(refpix[r][j], refpix[r][j+1],
                                          refpix[r+1][j], refpix[r+1][j+1], dx, dy));
    for (int k = 0; k < 400 && outs < BH; k++) begin
      #1;
      cmd_valid = !cmd_sent || hold_after;
      cmd_dx    = cmd_sent ? 3'(next_dx) : 3'(dx);
      cmd_dy    = cmd_sent ? 3'(next_dy) : 3'(dy);
      src_valid = cmd_sent && rows <= BH && (rdy_mode == 0 || $urandom_range(0, 3) != 0);
      src_row   = '0;
      if (rows <= BH)
        for (int i = 0; i <= BW; i++) src_row[i*PW +: PW] = refpix[rows][i];
      seen_valid = seen_valid || dst_valid;
      case (rdy_mode)
        0:       dst_ready = 1'b1;
        1:       dst_ready = 1'($urandom_range(0, 1));
        2:       dst_ready = !(seen_valid && stall < 3);
        default: dst_ready = 1'b1;
      endcase
      if (seen_valid && !dst_ready) stall++;
      #1;
      if (held_valid) begin
        chk("hold_row", dst_row, held_row);
        chk("hold_last", dst_last, held_last);
      end
      if (cmd_sent) chk("cmd_busy", cmd_ready, 0);
      if (dst_valid && !dst_ready) chk("bp_src_ready", src_ready, 0);
      held_valid = dst_valid && !dst_ready;
      held_row   = dst_row;
      held_last  = dst_last;
      if (!cmd_sent && cmd_valid && cmd_ready) begin
        cmd_sent = 1'b1;
        if (expect_b2b) chk("b2b_cmd_lat", cyc - last_dst_cyc, 1);
        expect_b2b = 1'b0;
      end
      if (src_valid && src_ready) rows++;
      if (dst_valid && dst_ready) begin
        chk($sformatf("row%0d", outs), dst_row, exp_rows[outs]);
        chk($sformatf("last%0d", outs), dst_last, (outs == BH-1));
        outs++;
        last_dst_cyc = cyc;
      end
      @(posedge clk);
      cyc++;
      if (abort_at > 0 && outs == abort_at) break;
    end
    if (abort_at == 0) begin
      chk("out_count", outs, BH);
      chk("src_count", rows, BH+1);
      #1;
      chk("idle_cmd_ready", cmd_ready, 1);
      chk("idle_src_ready", src_ready, 0);
      chk("idle_dst_valid", dst_valid, 0);
    end
    expect_b2b = hold_after;
  endtask

  initial begin
    reset     = 1'b1;
    cmd_valid = 1'b0;
    cmd_dx    = 3'd0;
    cmd_dy    = 3'd0;
    src_valid = 1'b0;
    src_row   = '0;
    dst_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("rst");
    reset = 1'b0;
    @(posedge clk);

    run_block(0, 0, 1, 0, 0, 1'b0, 0, 0);   // copy mode ramp
    run_block(4, 0, 2, 0, 0, 1'b0, 0, 0);   // half-pel horizontal -> 128
    run_block(7, 7, 3, 0, 0, 1'b0, 0, 0);   // corner weight 49 -> 195
    run_block(3, 5, 0, 2, 0, 1'b0, 0, 0);   // 3-cycle backpressure

    // abort mid-block with reset, then a clean copy block
    run_block(2, 6, 0, 1, 2, 1'b0, 0, 0);
    #1;
    reset     = 1'b1;
    cmd_valid = 1'b0;
    src_valid = 1'b0;
    #1;
    check_reset_outputs("mid_rst");
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    run_block(0, 0, 1, 0, 0, 1'b0, 0, 0);

    // command held during a busy block, accepted right after exit
    run_block(5, 1, 0, 1, 0, 1'b1, 6, 2);
    run_block(6, 2, 0, 1, 0, 1'b0, 0, 0);

    for (int t = 0; t < 20; t++)
      run_block($urandom_range(0, 7), $urandom_range(0, 7), 0,
                $urandom_range(0, 2), 0, 1'b0, 0, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
